// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl
//   Sequencer for one ChaCha block core with a byte-wide write/read port.
//   A run loads the 32-bit block counter into state bytes 48..51, waits for
//   the core's ready (with a watchdog), streams the 64 keystream bytes over
//   a valid/ready port, and repeats for num_blocks consecutive counters.
//   While idle, host key/nonce bytes pass straight through to the core.
//
//   Optional macro CHACHA_STREAM_XOR_EN: adds pt_valid/pt_data and emits
//   keystream XOR plaintext, with the stream paced by pt_valid.
//
// Ports
//   clk, rst_n                 clock (rising), async active-low reset
//   cfg_wr/cfg_addr/cfg_data   host config byte write, honoured when idle
//   start, abort               run control
//   ctr_init, num_blocks       run parameters, latched on start
//   busy, done, timeout,
//   ctr_wrap, ctr_out          status
//   ks_valid/ks_ready/ks_data  keystream output port
//   blk_*                      ChaCha core write/read interface
module chacha_stream_ctrl #(
    parameter logic [5:0] CTR_BYTE_ADDR = 6'd48,
    parameter int         BLOCK_BYTES   = 64,
    parameter logic [7:0] WAIT_MAX      = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_wr,
    input  logic [5:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] ctr_init,
    input  logic [7:0]  num_blocks,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        ctr_wrap,
    output logic [31:0] ctr_out,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic [7:0]  ks_data,
`ifdef CHACHA_STREAM_XOR_EN
    input  logic        pt_valid,
    input  logic [7:0]  pt_data,
`endif
    output logic        blk_write,
    output logic [5:0]  blk_addr,
    output logic [7:0]  blk_data_in,
    input  logic [7:0]  blk_data_out,
    input  logic        blk_ready
);

    localparam logic [5:0] LAST_IDX = 6'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STREAM} state_e;

    state_e      state_q;
    logic [5:0]  idx_q;      // LOAD byte k (low 2 bits) or STREAM byte index
    logic [7:0]  nblk_q;     // blocks still to produce, including current
    logic [7:0]  wdog_q;
    logic [31:0] ctr_q;
    logic        done_q, timeout_q, wrap_q;
    logic        accept;

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign ctr_wrap = wrap_q;
    assign ctr_out  = ctr_q;

`ifdef CHACHA_STREAM_XOR_EN
    assign ks_valid = (state_q == S_STREAM) && pt_valid;
    assign ks_data  = blk_data_out ^ pt_data;
`else
    assign ks_valid = (state_q == S_STREAM);
    assign ks_data  = blk_data_out;
`endif
    assign accept = ks_valid && ks_ready;

    // Core port mux: host pass-through when idle, counter bytes in LOAD,
    // read address in STREAM. Host writes while busy never reach the core.
    always_comb begin
        blk_write   = 1'b0;
        blk_addr    = 6'd0;
        blk_data_in = 8'd0;
        case (state_q)
            S_IDLE: begin
                blk_write   = cfg_wr;
                blk_addr    = cfg_addr;
                blk_data_in = cfg_data;
            end
            S_LOAD: begin
                blk_write   = 1'b1;
                blk_addr    = CTR_BYTE_ADDR + {4'd0, idx_q[1:0]};
                blk_data_in = ctr_q[{idx_q[1:0], 3'b000} +: 8];
            end
            S_STREAM: blk_addr = idx_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 6'd0;
            nblk_q    <= 8'd0;
            wdog_q    <= 8'd0;
            ctr_q     <= 32'd0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            timeout_q <= 1'b0;
                            wrap_q    <= 1'b0;
                            if (num_blocks != 8'd0) begin
                                ctr_q   <= ctr_init;
                                nblk_q  <= num_blocks;
                                idx_q   <= 6'd0;
                                state_q <= S_LOAD;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (idx_q[1:0] == 2'd3) begin
                            idx_q   <= 6'd0;
                            wdog_q  <= 8'd0;
                            state_q <= S_WAIT;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                    S_WAIT: begin
                        // ready wins over an expiry in the same cycle
                        if (blk_ready) begin
                            idx_q   <= 6'd0;
                            state_q <= S_STREAM;
                        end else if (wdog_q == WAIT_MAX - 8'd1) begin
                            timeout_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            wdog_q <= wdog_q + 8'd1;
                        end
                    end
                    S_STREAM: begin
                        if (accept) begin
                            if (idx_q == LAST_IDX) begin
                                nblk_q <= nblk_q - 8'd1;
                                idx_q  <= 6'd0;
                                if (nblk_q != 8'd1) begin
                                    ctr_q   <= ctr_q + 32'd1;
                                    state_q <= S_LOAD;
                                    if (ctr_q == 32'hFFFF_FFFF) wrap_q <= 1'b1;
                                end else begin
                                    done_q  <= 1'b1;
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                idx_q <= idx_q + 6'd1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
module tb_chacha_stream_ctrl;

    localparam logic [127:0] CONST_W  = 128'h6b206574_79622d32_3320646e_61707865;
    // RFC 8439 2.3.2 serialized block, byte 0 in the MSB position
    localparam logic [127:0] RFC_HEAD = 128'h10f1e7e4d13b5915500fdd1fa32071c4;
    localparam logic [127:0] RFC_TAIL = 128'hb5129cd1de164eb9cbd083e8a2503c4e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cfg_wr, start, abort, ks_ready;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_data, num_blocks;
    logic [31:0] ctr_init;
    logic        busy, done, timeout, ctr_wrap, ks_valid, blk_write, blk_ready;
    logic [31:0] ctr_out;
    logic [7:0]  ks_data, blk_data_in, blk_data_out;
    logic [5:0]  blk_addr;
`ifdef CHACHA_STREAM_XOR_EN
    logic        pt_valid = 1'b1;
    logic [7:0]  pt_data  = 8'h00;
`endif

    chacha_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .abort(abort), .ctr_init(ctr_init),
        .num_blocks(num_blocks), .busy(busy), .done(done), .timeout(timeout),
        .ctr_wrap(ctr_wrap), .ctr_out(ctr_out), .ks_valid(ks_valid),
        .ks_ready(ks_ready), .ks_data(ks_data),
`ifdef CHACHA_STREAM_XOR_EN
        .pt_valid(pt_valid), .pt_data(pt_data),
`endif
        .blk_write(blk_write), .blk_addr(blk_addr), .blk_data_in(blk_data_in),
        .blk_data_out(blk_data_out), .blk_ready(blk_ready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- ChaCha20 reference ----------------
    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a += b; d ^= a; d = {d[15:0], d[31:16]};
        c += d; b ^= c; b = {b[19:0], b[31:20]};
        a += b; d ^= a; d = {d[23:0], d[31:24]};
        c += d; b ^= c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha20(input logic [511:0] in);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = in[32*i +: 32];
        for (int n = 0; n < 10; n++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + in[32*i +: 32];
        return r;
    endfunction

    logic [255:0] key;
    logic [95:0]  nonce;

    function automatic logic [511:0] model_block(input logic [31:0] ctr);
        return chacha20({nonce, ctr, key, CONST_W});
    endfunction

    // ---------------- core model ----------------
    logic [511:0] core_st, core_out;
    logic         core_rdy, core_hold;
    int           core_cnt, core_lat;

    always @(posedge clk) begin
        if (!rst_n) begin
            core_rdy <= 1'b0;
            core_cnt <= 0;
        end else if (blk_write) begin
            core_st[8*blk_addr +: 8] <= blk_data_in;
            core_rdy <= 1'b0;
            core_cnt <= core_lat;
        end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
        end else if (core_cnt == 1) begin
            core_cnt <= 0;
            if (!core_hold) begin
                core_rdy <= 1'b1;
                core_out <= chacha20({core_st[511:128], CONST_W});
            end
        end
    end
    assign blk_ready    = core_rdy;
    assign blk_data_out = core_out[{blk_addr, 3'b000} +: 8];

    // ---------------- scoreboard / compare process ----------------
    logic [13:0] exp_wr [$];   // {addr, data} of expected counter writes
    logic [7:0]  exp_ks [$];
    logic [7:0]  cap [256];
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0, prev_abort = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                if (blk_write) begin
                    if (exp_wr.size() == 0) chk("busy_write_unexpected", {blk_addr, blk_data_in}, 14'h0);
                    else chk("ctr_write", {blk_addr, blk_data_in}, exp_wr.pop_front());
                end
            end else begin
                chk("idle_pass_wr", blk_write, cfg_wr);
                if (cfg_wr) chk("idle_pass_addr_data", {blk_addr, blk_data_in}, {cfg_addr, cfg_data});
                chk("idle_ks_valid", ks_valid, 1'b0);
            end
            if (ks_valid && ks_ready) begin
                if (exp_ks.size() == 0) chk("ks_extra_byte", ks_data, 8'h0);
                else chk("ks_byte", ks_data, exp_ks.pop_front());
                cap[acc_cnt % 256] = ks_data;
                acc_cnt <= acc_cnt + 1;
            end
            if (prev_stall && !prev_abort)
                chk("stall_hold", {ks_valid, ks_data}, {1'b1, prev_data});
            if (done) done_cnt <= done_cnt + 1;
            prev_stall <= ks_valid && !ks_ready;
            prev_data  <= ks_data;
            prev_abort <= abort;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [31:0] c, input logic [7:0] n);
        ctr_init = c; num_blocks = n; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic push_run(input logic [31:0] c, input logic [7:0] n, input bit ks);
        logic [31:0]  cb;
        logic [511:0] mb;
        for (int b = 0; b < int'(n); b++) begin
            cb = c + b;
            for (int k = 0; k < 4; k++) exp_wr.push_back({6'(48 + k), cb[8*k +: 8]});
            if (ks) begin
                mb = model_block(cb);
                for (int i = 0; i < 64; i++) exp_ks.push_back(mb[8*i +: 8]);
            end
        end
    endtask

    task automatic run(input logic [31:0] c, input logic [7:0] n, input bit bp);
        int d0, a0;
        bit seen;
        logic [32:0] last;
        push_run(c, n, 1'b1);
        d0 = done_cnt; a0 = acc_cnt; seen = 0;
        do_start(c, n);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            ks_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        chk("run_done_seen", seen, 1'b1);
        chk("run_busy_end", busy, 1'b0);
        last = {1'b0, c} + 33'(n) - 33'd1;
        chk("run_ctr_out", ctr_out, last[31:0]);
        chk("run_ctr_wrap", ctr_wrap, last[32]);
        chk("run_timeout", timeout, 1'b0);
        @(posedge clk); #1;
        ks_ready = 1'b1;
        chk("run_done_pulse", done, 1'b0);
        chk("run_done_count", done_cnt - d0, 1);
        chk("run_bytes", acc_cnt - a0, 64 * int'(n));
        chk("run_ks_left", exp_ks.size(), 0);
        chk("run_wr_left", exp_wr.size(), 0);
        exp_ks.delete(); exp_wr.delete();
    endtask

    initial begin
        logic [511:0] mb;
        logic [127:0] head, tail;
        int d0, a0, cnt;
        bit hit;

        rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
        abort = 1'b0; ks_ready = 1'b1; ctr_init = '0; num_blocks = '0;
        core_hold = 1'b0; core_lat = 161;
        for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
        nonce = '0; nonce[31:24] = 8'h09; nonce[63:56] = 8'h4a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", {busy, done, timeout, ctr_wrap, ks_valid, blk_write}, 6'b0);
        chk("reset_addr_data", {blk_addr, blk_data_in}, 14'h0);
        chk("reset_ctr", ctr_out, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // pin the model against the RFC test vector
        mb = model_block(32'd1);
        for (int i = 0; i < 16; i++) begin
            head[8*(15-i) +: 8] = mb[8*i +: 8];
            tail[8*(15-i) +: 8] = mb[8*(48+i) +: 8];
        end
        chk("model_rfc_head", head, RFC_HEAD);
        chk("model_rfc_tail", tail, RFC_TAIL);

        // key and nonce through the idle pass-through
        for (int i = 0; i < 44; i++) begin
            cfg_wr = 1'b1;
            cfg_addr = (i < 32) ? 6'(16 + i) : 6'(52 + i - 32);
            cfg_data = (i < 32) ? key[8*i +: 8] : nonce[8*(i-32) +: 8];
            @(posedge clk); #1;
        end
        cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;

        // RFC block with nominal core latency
        a0 = acc_cnt;
        run(32'd1, 8'd1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            head[8*(15-i) +: 8] = cap[(a0 + i) % 256];
            tail[8*(15-i) +: 8] = cap[(a0 + 48 + i) % 256];
        end
        chk("dut_rfc_head", head, RFC_HEAD);
        chk("dut_rfc_tail", tail, RFC_TAIL);

        core_lat = 20;
        run(32'd7, 8'd3, 1'b0);
        run(32'd7, 8'd3, 1'b1);
        run(32'hFFFF_FFFF, 8'd2, 1'b0);

        // empty run: done pulse only, sticky flags cleared
        d0 = done_cnt;
        do_start(32'h55, 8'd0);
        chk("empty_done", {done, busy}, 2'b10);
        chk("empty_wrap_clr", ctr_wrap, 1'b0);
        chk("empty_ctr_kept", ctr_out, 32'h0);
        @(posedge clk); #1;
        chk("empty_done_pulse", done, 1'b0);

        // watchdog
        core_hold = 1'b1;
        push_run(32'd5, 8'd1, 1'b0);
        d0 = done_cnt; cnt = 0; hit = 0;
        do_start(32'd5, 8'd1);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (done) begin hit = 1; break; end
            if (busy) cnt++;
        end
        chk("wd_done_seen", hit, 1'b1);
        chk("wd_busy_cycles", cnt, 259);
        chk("wd_flags", {timeout, busy}, 2'b10);
        @(posedge clk); #1;
        chk("wd_done_count", done_cnt - d0, 1);
        chk("wd_timeout_sticky", timeout, 1'b1);
        core_hold = 1'b0;
        exp_wr.delete();

        // abort at stream index 20 with a host write pending throughout
        push_run(32'h100, 8'd1, 1'b1);
        a0 = acc_cnt; d0 = done_cnt; hit = 0;
        do_start(32'h100, 8'd1);
        cfg_wr = 1'b1; cfg_addr = 6'd20; cfg_data = 8'hAA;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            if (acc_cnt - a0 >= 20) begin hit = 1; break; end
        end
        chk("abort_reached_20", hit, 1'b1);
        abort = 1'b1; ks_ready = 1'b0;
        @(negedge clk);
        chk("abort_idx", {busy, blk_addr, blk_write}, {1'b1, 6'd20, 1'b0});
        @(posedge clk); #1;
        cfg_wr = 1'b0; abort = 1'b0; cfg_addr = '0; cfg_data = '0;
        chk("abort_idle", {busy, ks_valid, done}, 3'b001);
        chk("abort_sticky", {timeout, ctr_wrap}, 2'b00);
        chk("abort_bytes", acc_cnt - a0, 20);
        exp_ks.delete(); exp_wr.delete();
        ks_ready = 1'b1;
        @(posedge clk); #1;
        chk("abort_done_pulse", done, 1'b0);
        chk("abort_done_count", done_cnt - d0, 1);
        run(32'd2, 8'd1, 1'b0);

        // async reset while waiting for the core
        push_run(32'h1234_5678, 8'd1, 1'b0);
        do_start(32'h1234_5678, 8'd1);
        repeat (7) @(posedge clk);
        #2;
        chk("rst_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_flags", {busy, done, timeout, ctr_wrap, ks_valid, blk_write}, 6'b0);
        chk("rst_addr_data", {blk_addr, blk_data_in}, 14'h0);
        chk("rst_ctr", ctr_out, 32'h0);
        exp_wr.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/chacha_stream_ctrl.md
Name: chacha_stream_ctrl

Overview:
- Sequencer that drives one ChaCha block core through its byte-wide write/read interface.
- On `start`, it writes the 32-bit block counter into state bytes 48..51 and waits for the core's `ready`.
- It then streams the 64 keystream bytes out over a valid/ready port, and repeats for `num_blocks` consecutive counter values.
- It also arbitrates host key/nonce configuration writes onto the same core write port while idle.

Parameters:
- CTR_BYTE_ADDR, 48: first byte address of state word 12 (block counter, little-endian).
- BLOCK_BYTES, 64: keystream bytes per block; stream index range 0..BLOCK_BYTES-1.
- WAIT_MAX, 255: watchdog limit in cycles for the core `ready` in WAIT_CORE; 8-bit counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_wr  in  1  host config byte write strobe; honoured only when busy=0.
- cfg_addr  in  6  host config byte address.
- cfg_data  in  8  host config byte.
- start  in  1  begin a run; sampled only when busy=0.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- ctr_init  in  32  starting block counter, latched on start.
- num_blocks  in  8  blocks to generate, latched on start; 0 = empty run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run, abort or timeout.
- timeout  out  1  sticky, set on watchdog expiry, cleared on next accepted start.
- ctr_wrap  out  1  sticky, set when counter increments from 0xFFFFFFFF to 0, cleared on next accepted start.
- ctr_out  out  32  current block counter.
- ks_valid  out  1  keystream byte valid.
- ks_ready  in  1  downstream accept.
- ks_data  out  8  keystream byte (or ciphertext, see Optional Feature).
- blk_write  out  1  to core write.
- blk_addr  out  6  to core addr_in; write address in LOAD, read address in STREAM.
- blk_data_in  out  8  to core data_in.
- blk_data_out  in  8  from core; combinational on blk_addr, same cycle.
- blk_ready  in  1  from core ready.

Behaviour:
- Reset (async): state=IDLE; busy, done, timeout, ctr_wrap, ks_valid, blk_write = 0; blk_addr, blk_data_in, ctr_out, byte index, block count, watchdog = 0.
- IDLE:
  - blk_write=cfg_wr, blk_addr=cfg_addr, blk_data_in=cfg_data (combinational pass-through).
  - start with num_blocks≠0: latch ctr_init into ctr_out, latch num_blocks, clear sticky flags, go to LOAD.
  - start with num_blocks=0: clear sticky flags, pulse done next cycle, stay IDLE.
- Config writes while busy=1 are dropped and never reach the core.
- LOAD: 4 cycles, blk_write=1.
  - Cycle k (k=0..3): blk_addr=CTR_BYTE_ADDR+k, blk_data_in=ctr_out[8k+7:8k].
  - After k=3, go to WAIT_CORE.
  - The core clears its ready on these write edges, so no stale ready is seen.
- WAIT_CORE: blk_write=0; watchdog increments each cycle.
  - blk_ready=1: go to STREAM, index=0.
  - Watchdog reaches WAIT_MAX: set timeout, pulse done, go to IDLE.
  - Nominal wait: 1 copy cycle + 160 round cycles.
- STREAM:
  - ks_valid=1, blk_addr=index, ks_data=blk_data_out.
  - Index advances only on ks_valid&&ks_ready; ks_data stays stable while stalled.
  - On accept of index BLOCK_BYTES-1:
    - Decrement block count.
    - If the remaining count is ≠0: ctr_out+1 (mod 2^32, set ctr_wrap on wrap), go to LOAD.
    - Otherwise pulse done and go to IDLE; ctr_out holds the last-used counter.
- abort has priority over all transitions in any busy state: next cycle IDLE, ks_valid=0, blk_write=0, done pulse. Sticky flags are unchanged.
- start while busy is ignored.
- Throughput with ks_ready tied high: 4 + (≥161) + 64 cycles per block.

Optional Feature:
- Macro CHACHA_STREAM_XOR_EN.
- Defined:
  - Adds inputs pt_valid (1) and pt_data (8).
  - In STREAM: ks_valid = pt_valid; accept = pt_valid&&ks_ready; ks_data = blk_data_out ^ pt_data.
  - pt_data is consumed exactly on accept.
- Undefined: these ports are absent and ks_data is the raw keystream byte.

Test Plan:
- Key/nonce via cfg_wr in IDLE, start with ctr_init=1, num_blocks=1, ks_ready=1 -> blk_addr 48..51 written with 01,00,00,00; 64 bytes equal to the RFC 8439 §2.3.2 block; done once; ctr_out=1.
- num_blocks=3, ctr_init=0x00000007 -> counter bytes written as 07, 08, 09 in successive LOADs; 192 bytes out; ctr_out=0x00000009.
- Random ks_ready backpressure (≈50%) -> no byte lost or duplicated; ks_data stable while stalled; stream matches the unstalled run.
- ctr_init=0xFFFFFFFF, num_blocks=2 -> second LOAD writes 00,00,00,00; ctr_wrap=1 until the next start.
- Core model holds blk_ready=0 -> timeout=1 after WAIT_MAX cycles in WAIT_CORE; done pulse; busy=0.
- abort mid-STREAM at index 20 -> IDLE next cycle, ks_valid=0. A cfg_wr issued while busy never asserts blk_write. rst_n pulsed low in WAIT_CORE clears all outputs immediately.
